// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receive FIFO: status decode from the
// fill level and the USTAT byte layout seen by the CPU.
package uart_rx_fifo_pkg;

    localparam int USTAT_TXBUSY = 0;
    localparam int USTAT_RXNE   = 4;
    localparam int USTAT_OVR    = 5;

    // Wide enough for a fill level of up to 256 bytes.
    typedef logic [8:0] level_t;

    typedef struct packed {
        logic not_empty;
        logic full;
        logic intr;
    } rx_status_t;

    function automatic rx_status_t decode_status(input level_t level,
                                                 input level_t depth,
                                                 input level_t thresh);
        rx_status_t s;
        s.not_empty = (level != 9'd0);
        s.full      = (level == depth);
        s.intr      = (level >= thresh);
        return s;
    endfunction

    function automatic logic [7:0] ustat_byte(input logic ovr,
                                              input logic rxne,
                                              input logic tx_busy);
        logic [7:0] u;
        u               = 8'h00;
        u[USTAT_OVR]    = ovr;
        u[USTAT_RXNE]   = rxne;
        u[USTAT_TXBUSY] = tx_busy;
        return u;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module uart_rx_fifo_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    // Write port: one byte per accepted push.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: queues bytes from the receiver, pops one byte per CPU
// read of the data register, and flags overrun / threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int THRESH     = 1
) (
    input  logic                  clock,
    input  logic                  RESET_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rd_strb,
    input  logic                  ovr_clr,
    output logic [7:0]            dout,
    output logic                  not_empty,
    output logic                  full,
    output logic                  overrun,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  rx_intr
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  overrun_r;
    logic                  rd_strb_d_r;
    rx_status_t            status_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DEPTH_LOG2:0]   count_next_s;
    rx_status_t            status_next_s;
    logic [7:0]            rd_data_s;

    // Edge-detect the CPU read so a long strobe pops once; a full FIFO still
    // accepts a byte when a pop frees the slot in the same cycle.
    always_comb begin
        pop_s  = rd_strb & ~rd_strb_d_r & status_r.not_empty;
        push_s = rx_valid & (~status_r.full | pop_s);
        drop_s = rx_valid & ~push_s;
        if (push_s & ~pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s & ~push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
        status_next_s = decode_status(level_t'(count_next_s), level_t'(DEPTH),
                                      level_t'(THRESH));
    end

    // Pointers, fill level, status flags and sticky overrun.
    always_ff @(posedge clock) begin
        if (!RESET_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            overrun_r   <= 1'b0;
            rd_strb_d_r <= 1'b0;
            status_r    <= '0;
        end else begin
            rd_strb_d_r <= rd_strb;
            count_r     <= count_next_s;
            status_r    <= status_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clock (clock),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (rx_data),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    assign dout      = status_r.not_empty ? rd_data_s : 8'h00;
    assign not_empty = status_r.not_empty;
    assign full      = status_r.full;
    assign rx_intr   = status_r.intr;
    assign overrun   = overrun_r;
    assign count     = count_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH 16, THRESH 4) against a
// queue-based model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TH    = 4;

    logic          clock = 1'b0;
    logic          RESET_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rd_strb;
    logic          ovr_clr;
    logic [7:0]    dout;
    logic          not_empty;
    logic          full;
    logic          overrun;
    logic [DL:0]   count;
    logic          rx_intr;

    int checks = 0;
    int errors = 0;

    byte unsigned q[$];
    bit           m_ovr  = 1'b0;
    bit           m_prev = 1'b0;

    always #5 clock = ~clock;

    uart_rx_fifo #(
        .DEPTH_LOG2 (DL),
        .THRESH     (TH)
    ) dut (
        .clock     (clock),
        .RESET_n   (RESET_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_strb   (rd_strb),
        .ovr_clr   (ovr_clr),
        .dout      (dout),
        .not_empty (not_empty),
        .full      (full),
        .overrun   (overrun),
        .count     (count),
        .rx_intr   (rx_intr)
    );

    function automatic logic [7:0] m_dout();
        return (q.size() != 0) ? 8'(q[0]) : 8'h00;
    endfunction

    // One clock cycle: drive inputs, clock, then advance the model.
    task automatic cyc(input bit rst_n, input bit v, input logic [7:0] d,
                       input bit rd, input bit clr);
        bit drop;
        RESET_n  = rst_n;
        rx_valid = v;
        rx_data  = d;
        rd_strb  = rd;
        ovr_clr  = clr;
        @(posedge clock);
        #1;
        drop = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_ovr  = 1'b0;
            m_prev = 1'b0;
        end else begin
            if (rd && !m_prev && q.size() != 0) q.delete(0);
            if (v) begin
                if (q.size() < DEPTH) q.push_back(d);
                else drop = 1'b1;
            end
            if (drop) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            m_prev = rd;
        end
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (not_empty !== 1'b0 || full !== 1'b0 || rx_intr !== 1'b0) begin errors++; $display("FAIL reset_flags got ne=%b f=%b i=%b want 0 0 0", not_empty, full, rx_intr); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        // traffic including an overrun, then reset with a byte arriving
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL pre_reset_overrun got %b want 1", overrun); end
        cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h98, 1'b0, 1'b0);
        idle();
        checks++; if (count !== 5'd0 || not_empty !== 1'b0) begin errors++; $display("FAIL midreset_empty got cnt=%0d ne=%b want 0 0", count, not_empty); end
        checks++; if (dout !== 8'h00 || overrun !== 1'b0) begin errors++; $display("FAIL midreset_dout_ovr got %h %b want 00 0", dout, overrun); end
    endtask

    task automatic test_order();
        cyc(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h43, 1'b0, 1'b0);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL order_count got %0d want 3", count); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (dout !== 8'(8'h41 + k)) begin errors++; $display("FAIL order_dout got %h want %h", dout, 8'(8'h41 + k)); end
            for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            idle();
        end
        checks++; if (not_empty !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL order_empty got ne=%b dout=%h want 0 00", not_empty, dout); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || overrun !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_state got f=%b o=%b cnt=%0d want 1 1 16", full, overrun, count); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL ovf_drain got %h want %h", dout, 8'(i)); end
            pop1();
        end
        checks++; if (not_empty !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovf_lost got ne=%b o=%b want 0 1", not_empty, overrun); end
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overrun); end
    endtask

    task automatic test_wrap();
        cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 40; i++) begin
            checks++; if (dout !== 8'(i - 1)) begin errors++; $display("FAIL wrap_order got %h want %h", dout, 8'(i - 1)); end
            cyc(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
            idle();
            checks++; if (count > 5'd2 || count !== 5'(q.size())) begin errors++; $display("FAIL wrap_count got %0d want %0d", count, q.size()); end
        end
        checks++; if (dout !== 8'h27) begin errors++; $display("FAIL wrap_last got %h want 27", dout); end
        pop1();
    endtask

    task automatic test_simul();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        idle();
        checks++; if (count !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL simul_full got cnt=%0d o=%b f=%b want 16 0 1", count, overrun, full); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout !== m_dout()) begin errors++; $display("FAIL simul_drain got %h want %h", dout, m_dout()); end
            if (i == 15) begin
                checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL simul_last got %h want aa", dout); end
            end
            pop1();
        end
        cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        checks++; if (count !== 5'd1 || dout !== 8'h5A) begin errors++; $display("FAIL simul_empty got cnt=%0d dout=%h want 1 5a", count, dout); end
        idle();
        pop1();
    endtask

    task automatic test_thresh();
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b1, 8'(k), 1'b0, 1'b0);
            checks++; if (rx_intr !== (k >= TH)) begin errors++; $display("FAIL thresh_rise got %b want %b at %0d", rx_intr, (k >= TH), k); end
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rx_intr !== 1'b0 || count !== 5'd3) begin errors++; $display("FAIL thresh_fall got i=%b cnt=%0d want 0 3", rx_intr, count); end
        idle();
        for (int k = 0; k < 3; k++) pop1();
        pop1();
        checks++; if (count !== 5'd0 || not_empty !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL pop_empty got cnt=%0d ne=%b o=%b want 0 0 0", count, not_empty, overrun); end
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_vs_drop got %b want 1", overrun); end
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_after got %b want 0", overrun); end
    endtask

    task automatic test_random();
        bit v;
        bit rd;
        bit clr;
        for (int n = 0; n < 400; n++) begin
            if (n < 200) begin
                v  = ($urandom_range(0, 1) == 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                v  = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 1) == 0);
            end
            clr = ($urandom_range(0, 15) == 0);
            cyc(1'b1, v, 8'($urandom), rd, clr);
            checks++;
            if (count !== 5'(q.size()) || dout !== m_dout() || overrun !== m_ovr ||
                not_empty !== (q.size() != 0) || full !== (q.size() == DEPTH) ||
                rx_intr !== (q.size() >= TH)) begin
                errors++;
                $display("FAIL random got cnt=%0d dout=%h o=%b ne=%b f=%b i=%b want cnt=%0d dout=%h o=%b",
                         count, dout, overrun, not_empty, full, rx_intr, q.size(), m_dout(), m_ovr);
            end
        end
    endtask

    initial begin
        RESET_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rd_strb  = 1'b0;
        ovr_clr  = 1'b0;
        test_reset();
        test_order();
        test_overflow();
        test_wrap();
        test_simul();
        test_thresh();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
